// File: rtl/instr_fetch_if.sv
// Fetch-side bus: program-store read port and the instruction register
// handshake towards decode. The fetch unit is the master; the program store
// and decode together form the slave side.
interface instr_fetch_if #(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_instr;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic               ir_ready;

  modport master (
    output rom_addr,
    input  rom_instr,
    output ir,
    output ir_pc,
    output ir_valid,
    input  ir_ready
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    input  ir,
    input  ir_pc,
    input  ir_valid,
    output ir_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-entry instruction register fed from a
// combinational-read program store, with stall, redirect and a saturating
// fetch counter.
// Optional feature macro: FETCH_WRAP_HALT_EN -- when defined, a load from the
// last program address parks the unit in HALT until a redirect or reset.
//
// state | meaning
// IDLE  | not fetching; waits for run
// FETCH | issuing loads whenever the instruction register can take one
// HALT  | program ran off the end; only a redirect or reset leaves it
module instr_fetch #(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted,
  output logic [7:0]        fetch_count,
  instr_fetch_if.master     bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic               ir_valid_q;
  logic [7:0]         cnt_q;
  logic               load;

  assign bus.rom_addr = pc;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign fetch_count  = cnt_q;

`ifdef FETCH_WRAP_HALT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Load decision and next-state logic; a redirect outranks everything.
  always_comb begin
    load      = (state == ST_FETCH) && run && !br_taken &&
                (!ir_valid_q || bus.ir_ready);
    state_nxt = state;
    if (br_taken) begin
      state_nxt = run ? ST_FETCH : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          if (!run) begin
            state_nxt = ST_IDLE;
          end
`ifdef FETCH_WRAP_HALT_EN
          else if (load && (pc == {ADDR_W{1'b1}})) begin
            state_nxt = ST_HALT;
          end
`endif
        end
        ST_HALT: begin
          state_nxt = ST_HALT;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // PC, instruction register and fetch counter; a stall simply holds all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else if (br_taken) begin
      pc         <= br_target;
      ir_valid_q <= 1'b0;
    end else if (load) begin
      ir_q       <= bus.rom_instr;
      ir_pc_q    <= pc;
      ir_valid_q <= 1'b1;
      pc         <= pc + ADDR_W'(1);
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end else if (ir_valid_q && bus.ir_ready) begin
      ir_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of per-cycle vectors followed by a
// long run that drives the fetch counter into saturation.
module tb_instr_fetch;

  localparam int AW = 3;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          halted;
  logic [7:0]    fetch_count;

  instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halted      (halted),
    .fetch_count (fetch_count),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  // Program store: distinct word per address, combinational read.
  function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
    return 16'hA000 + 16'(a) * 16'h0011;
  endfunction

  assign bus.rom_instr = rom_word(bus.rom_addr);

  typedef struct {
    logic          rst;
    logic          run;
    logic          rdy;
    logic          br;
    logic [AW-1:0] tgt;
    logic [IW-1:0] e_ir;
    logic [AW-1:0] e_pc;
    logic          e_v;
    logic [AW-1:0] e_addr;
    logic          e_halt;
    logic [7:0]    e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(input logic r, input logic rn, input logic rd,
                              input logic b, input logic [AW-1:0] t,
                              input logic [IW-1:0] eir, input logic [AW-1:0] epc,
                              input logic ev, input logic [AW-1:0] ea,
                              input logic eh, input logic [7:0] ec);
    vec_t v;
    v.rst = r; v.run = rn; v.rdy = rd; v.br = b; v.tgt = t;
    v.e_ir = eir; v.e_pc = epc; v.e_v = ev; v.e_addr = ea;
    v.e_halt = eh; v.e_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic check_vec(input int idx, input vec_t v);
    n_vec++;
    if (bus.ir !== v.e_ir) begin
      n_miss++;
      $display("FAIL v%0d ir: got %h want %h", idx, bus.ir, v.e_ir);
    end
    if (bus.ir_pc !== v.e_pc) begin
      n_miss++;
      $display("FAIL v%0d ir_pc: got %0d want %0d", idx, bus.ir_pc, v.e_pc);
    end
    if (bus.ir_valid !== v.e_v) begin
      n_miss++;
      $display("FAIL v%0d ir_valid: got %b want %b", idx, bus.ir_valid, v.e_v);
    end
    if (bus.rom_addr !== v.e_addr) begin
      n_miss++;
      $display("FAIL v%0d rom_addr: got %0d want %0d", idx, bus.rom_addr, v.e_addr);
    end
    if (halted !== v.e_halt) begin
      n_miss++;
      $display("FAIL v%0d halted: got %b want %b", idx, halted, v.e_halt);
    end
    if (fetch_count !== v.e_cnt) begin
      n_miss++;
      $display("FAIL v%0d fetch_count: got %0d want %0d", idx, fetch_count, v.e_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; br_taken = 1'b0; br_target = '0; bus.ir_ready = 1'b1;

    //   rst run rdy br tgt  ir        irpc v  addr halt cnt
    add(1, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 8'd0);   // reset
    add(0, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 8'd0);   // IDLE -> FETCH
    add(0, 1, 1, 0, 0, 16'hA000, 0, 1, 1, 0, 8'd1);   // first load
    add(0, 1, 1, 0, 0, 16'hA011, 1, 1, 2, 0, 8'd2);
    add(0, 1, 1, 0, 0, 16'hA022, 2, 1, 3, 0, 8'd3);
    add(0, 1, 0, 0, 0, 16'hA022, 2, 1, 3, 0, 8'd3);   // stall x3 at ir_pc=2
    add(0, 1, 0, 0, 0, 16'hA022, 2, 1, 3, 0, 8'd3);
    add(0, 1, 0, 0, 0, 16'hA022, 2, 1, 3, 0, 8'd3);
    add(0, 1, 1, 0, 0, 16'hA033, 3, 1, 4, 0, 8'd4);   // released: word 3
    add(0, 1, 0, 0, 0, 16'hA033, 3, 1, 4, 0, 8'd4);   // stall, count 4
    add(1, 1, 0, 1, 6, 16'h0000, 0, 0, 0, 0, 8'd0);   // reset mid-stall beats branch
    add(0, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 8'd0);
    add(0, 1, 1, 0, 0, 16'hA000, 0, 1, 1, 0, 8'd1);
    add(0, 1, 1, 0, 0, 16'hA011, 1, 1, 2, 0, 8'd2);
    add(0, 1, 0, 1, 5, 16'hA011, 1, 0, 5, 0, 8'd2);   // redirect over stall
    add(0, 1, 1, 0, 0, 16'hA055, 5, 1, 6, 0, 8'd3);   // load from target
    add(0, 1, 1, 1, 2, 16'hA055, 5, 0, 2, 0, 8'd3);   // redirect + accept
    add(0, 1, 1, 0, 0, 16'hA022, 2, 1, 3, 0, 8'd4);
    add(0, 0, 1, 0, 0, 16'hA022, 2, 0, 3, 0, 8'd4);   // run=0: accept, PC holds
    add(0, 0, 1, 0, 0, 16'hA022, 2, 0, 3, 0, 8'd4);
    add(0, 1, 1, 0, 0, 16'hA022, 2, 0, 3, 0, 8'd4);   // IDLE -> FETCH
    add(0, 1, 1, 0, 0, 16'hA033, 3, 1, 4, 0, 8'd5);   // resume at held PC
    add(0, 1, 1, 0, 0, 16'hA044, 4, 1, 5, 0, 8'd6);
    add(0, 1, 1, 0, 0, 16'hA055, 5, 1, 6, 0, 8'd7);
    add(0, 1, 1, 0, 0, 16'hA066, 6, 1, 7, 0, 8'd8);
`ifdef FETCH_WRAP_HALT_EN
    add(0, 1, 1, 0, 0, 16'hA077, 7, 1, 0, 1, 8'd9);   // load from 7 -> HALT
    add(0, 1, 1, 0, 0, 16'hA077, 7, 0, 0, 1, 8'd9);   // no load in HALT
    add(0, 1, 1, 1, 0, 16'hA077, 7, 0, 0, 0, 8'd9);   // redirect leaves HALT
    add(0, 1, 1, 0, 0, 16'hA000, 0, 1, 1, 0, 8'd10);
    add(0, 0, 0, 0, 0, 16'hA000, 0, 1, 1, 0, 8'd10);  // stall with run=0
    add(0, 0, 1, 0, 0, 16'hA000, 0, 0, 1, 0, 8'd10);
`else
    add(0, 1, 1, 0, 0, 16'hA077, 7, 1, 0, 0, 8'd9);   // wrap, keep going
    add(0, 1, 1, 0, 0, 16'hA000, 0, 1, 1, 0, 8'd10);
    add(0, 1, 1, 1, 0, 16'hA000, 0, 0, 0, 0, 8'd10);  // redirect to 0
    add(0, 1, 1, 0, 0, 16'hA000, 0, 1, 1, 0, 8'd11);
    add(0, 0, 0, 0, 0, 16'hA000, 0, 1, 1, 0, 8'd11);  // stall with run=0
    add(0, 0, 1, 0, 0, 16'hA000, 0, 0, 1, 0, 8'd11);
`endif

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; run = vecs[i].run; bus.ir_ready = vecs[i].rdy;
      br_taken = vecs[i].br; br_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      check_vec(i, vecs[i]);
    end

    // Saturation: reset, then keep fetching (redirecting out of HALT if it occurs).
    rst = 1'b1; run = 1'b1; bus.ir_ready = 1'b1; br_taken = 1'b0; br_target = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      br_taken = halted;
    end
    br_taken = 1'b0;
    n_vec++;
    if (fetch_count !== 8'd255) begin
      n_miss++;
      $display("FAIL sat fetch_count: got %0d want 255", fetch_count);
    end
    // A further reset clears the saturated counter.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (fetch_count !== 8'd0 || bus.rom_addr !== 3'd0 || bus.ir_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL post_sat_reset: got cnt=%0d addr=%0d v=%b want 0 0 0",
               fetch_count, bus.rom_addr, bus.ir_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
